// File: rtl/antares_pkg.sv
// ---------------------------------------------------------------------------
// antares_pkg
// Shared constants for the Antares-R2 pipelined datapath.
//   DEFAULT_ADDR_WIDTH  : default width of the PC and all addresses
//   DEFAULT_INSTR_WIDTH : default instruction word width
//   DEFAULT_RESET_PC    : PC value loaded on reset
//   DEFAULT_NOP_WORD    : bubble instruction (sll $0,$0,0)
//   PC_INCREMENT        : byte distance between sequential instructions
// ---------------------------------------------------------------------------
package antares_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
    localparam int unsigned DEFAULT_INSTR_WIDTH = 32;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    localparam int unsigned PC_INCREMENT = 4;

endpackage : antares_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping, so a long run
// never reports a misleadingly small value.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high clear
//   inc   : count one event this cycle
//   count : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    // Count up on each requested event until every bit is set, then hold
    // there; reset clears the count regardless of inc.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule : sat_counter

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage plus IF/ID pipeline register of Antares-R2.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   stallIF       : 1 = PC may advance, 0 = hold PC (from hazard unit)
//   ifIdWrite     : 1 = IF/ID loads, 0 = IF/ID holds (from hazard unit)
//   branchTaken   : branch resolved taken in EX
//   branchTarget  : branch destination
//   jump          : jump decoded in ID
//   jumpTarget    : jump destination
//   imemAddr      : instruction-memory address (copy of the PC)
//   imemData      : instruction word read combinationally at imemAddr
//   pcID          : PC of the instruction held in IF/ID
//   pcPlus4ID     : pcID + 4
//   instrID       : instruction held in IF/ID
//   validID       : 1 = real instruction, 0 = bubble
//   stallCount    : saturating count of stall cycles without a redirect
//   flushCount    : saturating count of redirects
// ---------------------------------------------------------------------------
module fetch_stage
    import antares_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                     INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = DEFAULT_NOP_WORD,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stallIF,
    input  logic                   ifIdWrite,
    input  logic                   branchTaken,
    input  logic [ADDR_WIDTH-1:0]  branchTarget,
    input  logic                   jump,
    input  logic [ADDR_WIDTH-1:0]  jumpTarget,
    output logic [ADDR_WIDTH-1:0]  imemAddr,
    input  logic [INSTR_WIDTH-1:0] imemData,
    output logic [ADDR_WIDTH-1:0]  pcID,
    output logic [ADDR_WIDTH-1:0]  pcPlus4ID,
    output logic [INSTR_WIDTH-1:0] instrID,
    output logic                   validID,
    output logic [CNT_WIDTH-1:0]   stallCount,
    output logic [CNT_WIDTH-1:0]   flushCount
);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pcPlus4;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic                  redirect;
    logic                  stallEvent;

    // A redirect is any control-flow change arriving this cycle; the
    // instruction just fetched is on the wrong path whenever one occurs.
    // A stall is only counted when no redirect overrides it, because a
    // redirected cycle does not actually hold the PC. The sequential PC
    // wraps naturally modulo 2^ADDR_WIDTH.
    always_comb begin
        redirect   = branchTaken | jump;
        stallEvent = ~stallIF & ~redirect;
        pcPlus4    = pc + ADDR_WIDTH'(PC_INCREMENT);
    end

    // Next-PC selection. The branch comes from EX and so belongs to an older
    // instruction than the jump in ID, which is why it is checked first.
    // Either redirect beats a stall since the stalled path is discarded.
    always_comb begin
        pcNext = pcPlus4;
        if (branchTaken) begin
            pcNext = branchTarget;
        end else if (jump) begin
            pcNext = jumpTarget;
        end else if (!stallIF) begin
            pcNext = pc;
        end
    end

    // PC register; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pcNext;
        end
    end

    assign imemAddr = pc;

    // IF/ID pipeline register. On a redirect the fetched word is replaced
    // by a bubble while the PC fields are left alone, since a bubble's PC is
    // never consumed downstream. Otherwise the hazard unit decides whether
    // the register captures the current fetch or holds its contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcID      <= '0;
            pcPlus4ID <= '0;
            instrID   <= NOP_WORD;
            validID   <= 1'b0;
        end else if (redirect) begin
            instrID <= NOP_WORD;
            validID <= 1'b0;
        end else if (ifIdWrite) begin
            pcID      <= pc;
            pcPlus4ID <= pcPlus4;
            instrID   <= imemData;
            validID   <= 1'b1;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) stallCounter (
        .clk  (clk),
        .reset(reset),
        .inc  (stallEvent),
        .count(stallCount)
    );

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) flushCounter (
        .clk  (clk),
        .reset(reset),
        .inc  (redirect),
        .count(flushCount)
    );

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, each cycle compared against a behavioural model of the
// fetch stage and its counters.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          CNT_MAX = 65535;

    logic        clk;
    logic        reset;
    logic        stallIF;
    logic        ifIdWrite;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic        jump;
    logic [31:0] jumpTarget;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic [31:0] pcID;
    logic [31:0] pcPlus4ID;
    logic [31:0] instrID;
    logic        validID;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    int checks = 0;
    int errors = 0;

    logic [31:0] mPc;
    logic [31:0] mPcID;
    logic [31:0] mPcPlus4ID;
    logic [31:0] mInstrID;
    logic        mValidID;
    int          mStallCount;
    int          mFlushCount;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stallIF     (stallIF),
        .ifIdWrite   (ifIdWrite),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .jump        (jump),
        .jumpTarget  (jumpTarget),
        .imemAddr    (imemAddr),
        .imemData    (imemData),
        .pcID        (pcID),
        .pcPlus4ID   (pcPlus4ID),
        .instrID     (instrID),
        .validID     (validID),
        .stallCount  (stallCount),
        .flushCount  (flushCount)
    );

    // 10-time-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: each word encodes its own address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return 32'h1000_0000 | addr;
    endfunction

    assign imemData = memWord(imemAddr);

    // Compare one observed value against the bench's expectation.
    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance the reference model by one rising edge given the inputs that
    // were present at that edge.
    task automatic modelEdge(input logic rst, input logic st, input logic iw,
                             input logic bt, input logic [31:0] btgt,
                             input logic j, input logic [31:0] jt);
        logic redirectNow;
        if (rst) begin
            mPc         = RST_PC;
            mPcID       = 32'h0;
            mPcPlus4ID  = 32'h0;
            mInstrID    = NOP;
            mValidID    = 1'b0;
            mStallCount = 0;
            mFlushCount = 0;
        end else begin
            redirectNow = bt || j;
            if (redirectNow) begin
                mInstrID = NOP;
                mValidID = 1'b0;
            end else if (iw) begin
                mInstrID   = memWord(mPc);
                mPcID      = mPc;
                mPcPlus4ID = mPc + 32'd4;
                mValidID   = 1'b1;
            end
            if (!st && !redirectNow)
                mStallCount = (mStallCount < CNT_MAX) ? mStallCount + 1 : CNT_MAX;
            if (redirectNow)
                mFlushCount = (mFlushCount < CNT_MAX) ? mFlushCount + 1 : CNT_MAX;
            if (bt)       mPc = btgt;
            else if (j)   mPc = jt;
            else if (st)  mPc = mPc + 32'd4;
        end
    endtask

    // Compare every DUT output against the reference model.
    task automatic checkOutput();
        checkVal("imemAddr",   imemAddr,              mPc);
        checkVal("pcID",       pcID,                  mPcID);
        checkVal("pcPlus4ID",  pcPlus4ID,             mPcPlus4ID);
        checkVal("instrID",    instrID,               mInstrID);
        checkVal("validID",    {31'b0, validID},      {31'b0, mValidID});
        checkVal("stallCount", {16'b0, stallCount},   32'(mStallCount));
        checkVal("flushCount", {16'b0, flushCount},   32'(mFlushCount));
    endtask

    // Drive one cycle of inputs away from the rising edge, let the edge
    // happen, update the model and optionally compare shortly afterwards.
    task automatic applyStimulus(input logic rst, input logic st, input logic iw,
                                 input logic bt, input logic [31:0] btgt,
                                 input logic j, input logic [31:0] jt,
                                 input bit doCheck);
        reset        = rst;
        stallIF      = st;
        ifIdWrite    = iw;
        branchTaken  = bt;
        branchTarget = btgt;
        jump         = j;
        jumpTarget   = jt;
        @(posedge clk);
        modelEdge(rst, st, iw, bt, btgt, j, jt);
        #1;
        if (doCheck) checkOutput();
        @(negedge clk);
    endtask

    task automatic runFree(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic        rRst, rSt, rIw, rBt, rJ;
        logic [31:0] rBtgt, rJt;

        reset = 1'b1; stallIF = 1'b1; ifIdWrite = 1'b1;
        branchTaken = 1'b0; branchTarget = 32'h0;
        jump = 1'b0; jumpTarget = 32'h0;
        @(negedge clk);

        // Reset state.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkVal("rst_pc",      imemAddr,           32'h0);
        checkVal("rst_valid",   {31'b0, validID},   32'h0);
        checkVal("rst_instr",   instrID,            NOP);
        checkVal("rst_stallCnt", {16'b0, stallCount}, 32'h0);

        // Free run 0, 4, 8 then observe the fetch of 8 in IF/ID.
        runFree(2);
        checkVal("free_pc8",    imemAddr,           32'h8);
        runFree(1);
        checkVal("free_instr",  instrID,            32'h1000_0008);
        checkVal("free_pcID",   pcID,               32'h8);
        checkVal("free_pc4ID",  pcPlus4ID,          32'hC);
        checkVal("free_valid",  {31'b0, validID},   32'h1);
        runFree(1);
        checkVal("free_pc10",   imemAddr,           32'h10);

        // Load-use stall for two cycles at pc 0x10.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkVal("stall1_pc",   imemAddr,           32'h10);
        checkVal("stall1_pcID", pcID,               32'hC);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkVal("stall2_pc",   imemAddr,           32'h10);
        checkVal("stall2_pcID", pcID,               32'hC);
        checkVal("stall_cnt",   {16'b0, stallCount}, 32'd2);
        runFree(1);
        checkVal("release_pc",  imemAddr,           32'h14);

        // Branch while stalled: redirect wins, bubble inserted.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1);
        checkVal("brst_pc",     imemAddr,           32'h40);
        checkVal("brst_instr",  instrID,            NOP);
        checkVal("brst_valid",  {31'b0, validID},   32'h0);
        checkVal("brst_flush",  {16'b0, flushCount}, 32'd1);
        checkVal("brst_stall",  {16'b0, stallCount}, 32'd2);

        // Branch and jump together: branch wins, single bubble.
        runFree(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'hC0, 1'b1);
        checkVal("bj_pc",       imemAddr,           32'h80);
        checkVal("bj_valid",    {31'b0, validID},   32'h0);
        checkVal("bj_flush",    {16'b0, flushCount}, 32'd2);
        runFree(1);
        checkVal("bj_after",    {31'b0, validID},   32'h1);
        checkVal("bj_afterPc",  pcID,               32'h80);

        // Wrap-around from the top of the address space.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
        runFree(1);
        checkVal("wrap_pc",     imemAddr,           32'h0);
        checkVal("wrap_pcID",   pcID,               32'hFFFF_FFFC);
        checkVal("wrap_pc4ID",  pcPlus4ID,          32'h0);

        // Randomized run against the model, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rRst  = ($urandom_range(0, 49) == 0);
            rSt   = ($urandom_range(0, 3) != 0);
            rIw   = rSt ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
            rBt   = ($urandom_range(0, 7) == 0);
            rJ    = ($urandom_range(0, 7) == 0);
            rBtgt = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
            rJt   = $urandom & 32'hFFFF_FFFC;
            applyStimulus(rRst, rSt, rIw, rBt, rBtgt, rJ, rJt, 1'b1);
        end

        // Saturation of the stall counter, then reset in mid-redirect.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < CNT_MAX; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput();
        checkVal("sat_full",    {16'b0, stallCount}, 32'h0000_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checkVal("sat_hold",    {16'b0, stallCount}, 32'h0000_FFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h800, 1'b1);
        checkVal("rst2_pc",     imemAddr,           RST_PC);
        checkVal("rst2_valid",  {31'b0, validID},   32'h0);
        checkVal("rst2_stall",  {16'b0, stallCount}, 32'h0);
        checkVal("rst2_flush",  {16'b0, flushCount}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_stage
